// File: rtl/bcd_countdown_timer_pkg.sv
// timer_pkg: shared types and constants for the BCD count-down timer.
//   state_t      - controller states (2-bit encoding)
//   BCD_MAX_*    - largest legal value of each displayed digit
//   clamp_digit  - saturates a loaded digit to its legal maximum
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_UNI = 4'd9;
  localparam logic [3:0] BCD_MAX_DEZ = 4'd5;
  localparam logic [3:0] BCD_MAX_MIN = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_gen.sv
// tick_gen: prescaler that produces the 1 s tick for the count-down timer.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - count enable; the prescaler holds its value while low
//   clr   - synchronous clear of the prescaler (wins over en)
//   tick  - one-cycle pulse during the cycle in which the prescaler wraps
module tick_gen #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  // Combinational so the decrement lands on the same edge as the wrap.
  assign tick = en && (count_reg == LAST);

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: M:SS count-down timer (0:00..9:59) held as three BCD digits.
//   clk, rst_n                  - clock and asynchronous active-low reset
//   clear, load, start, stop    - level commands, priority clear > load > stop > start
//   LoadMin, LoadDez, LoadUni   - BCD time to load (clamped to 9, 5, 9)
//   Minutos, DezenaSeg, UnidadeSeg - registered BCD digits for the 7-segment decoder
//   running, done               - registered state flags (RUNNING / DONE)
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] LoadMin,
  input  logic [3:0] LoadDez,
  input  logic [3:0] LoadUni,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSeg,
  output logic [3:0] UnidadeSeg,
  output logic       running,
  output logic       done
);

  state_t     state_reg, state_next;
  logic [3:0] min_next, dez_next, uni_next;
  logic [3:0] dec_min, dec_dez, dec_uni;
  logic       tick, tick_clr, tick_en;
  logic       do_load, do_start, time_zero, dec_zero;

  // load is not a command while counting; stop outranks start.
  assign do_load   = load && (state_reg != RUNNING);
  assign do_start  = start && !stop;
  assign time_zero = (Minutos == 4'd0) && (DezenaSeg == 4'd0) && (UnidadeSeg == 4'd0);

  // Derived from registered state and inputs only, so there is no loop through tick.
  assign tick_en  = (state_reg == RUNNING);
  assign tick_clr = clear || do_load || ((state_reg == IDLE) && do_start && !time_zero);

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  // One-second BCD borrow chain. Minutes never underflow: 0:00 leaves RUNNING.
  always_comb begin
    dec_min = Minutos;
    dec_dez = DezenaSeg;
    dec_uni = UnidadeSeg - 4'd1;
    if (UnidadeSeg == 4'd0) begin
      dec_uni = BCD_MAX_UNI;
      if (DezenaSeg == 4'd0) begin
        dec_dez = BCD_MAX_DEZ;
        dec_min = Minutos - 4'd1;
      end else begin
        dec_dez = DezenaSeg - 4'd1;
      end
    end
  end

  assign dec_zero = (dec_min == 4'd0) && (dec_dez == 4'd0) && (dec_uni == 4'd0);

  always_comb begin
    state_next = state_reg;
    min_next   = Minutos;
    dez_next   = DezenaSeg;
    uni_next   = UnidadeSeg;
    if (clear) begin
      state_next = IDLE;
      min_next   = 4'd0;
      dez_next   = 4'd0;
      uni_next   = 4'd0;
    end else if (do_load) begin
      state_next = IDLE;
      min_next   = clamp_digit(LoadMin, BCD_MAX_MIN);
      dez_next   = clamp_digit(LoadDez, BCD_MAX_DEZ);
      uni_next   = clamp_digit(LoadUni, BCD_MAX_UNI);
    end else begin
      case (state_reg)
        IDLE: begin
          if (do_start && !time_zero) state_next = RUNNING;
        end
        RUNNING: begin
          // A stop on the wrap cycle still takes the decrement; reaching 0:00 beats the stop.
          if (tick) begin
            min_next = dec_min;
            dez_next = dec_dez;
            uni_next = dec_uni;
          end
          if (tick && dec_zero) state_next = DONE;
          else if (stop)        state_next = PAUSED;
        end
        PAUSED: begin
          if (do_start) state_next = RUNNING;
        end
        default: begin
          state_next = DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      Minutos    <= 4'd0;
      DezenaSeg  <= 4'd0;
      UnidadeSeg <= 4'd0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      Minutos    <= min_next;
      DezenaSeg  <= dez_next;
      UnidadeSeg <= uni_next;
      running    <= (state_next == RUNNING);
      done       <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer with TICKS_PER_SEC = 4.
// Table of one-cycle vectors driven in order; expected outputs go through a
// scoreboard queue and are compared #1 after the clock edge.
module tb_bcd_countdown_timer;

  logic       clk, rst_n;
  logic       clear, load, start, stop;
  logic [3:0] LoadMin, LoadDez, LoadUni;
  logic [3:0] Minutos, DezenaSeg, UnidadeSeg;
  logic       running, done;

  int assertions = 0;
  int failures   = 0;

  bcd_countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load      (load),
    .start     (start),
    .stop      (stop),
    .LoadMin   (LoadMin),
    .LoadDez   (LoadDez),
    .LoadUni   (LoadUni),
    .Minutos   (Minutos),
    .DezenaSeg (DezenaSeg),
    .UnidadeSeg(UnidadeSeg),
    .running   (running),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c, l, st, sp;
    logic [3:0] m, d, u;
    logic [13:0] exp;   // {min, dez, uni, running, done}
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] exp_q[$];

  task automatic add(input logic c, l, st, sp, input logic [3:0] m, d, u,
                     input logic [3:0] em, ed, eu, input logic er, edn, input int n);
    vec_t v;
    v.c = c; v.l = l; v.st = st; v.sp = sp;
    v.m = m; v.d = d; v.u = u;
    v.exp = {em, ed, eu, er, edn};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  function automatic logic [13:0] outs();
    return {Minutos, DezenaSeg, UnidadeSeg, running, done};
  endfunction

  task automatic check(input string name, input logic [13:0] expv);
    logic [13:0] got;
    got = outs();
    assertions++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0h:%0h%0h run=%0b done=%0b, required %0h:%0h%0h run=%0b done=%0b",
               name, got[13:10], got[9:6], got[5:2], got[1], got[0],
               expv[13:10], expv[9:6], expv[5:2], expv[1], expv[0]);
    end else begin
      $display("ok   %s: %0h:%0h%0h run=%0b done=%0b", name, got[13:10], got[9:6], got[5:2], got[1], got[0]);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    clear = v.c; load = v.l; start = v.st; stop = v.sp;
    LoadMin = v.m; LoadDez = v.d; LoadUni = v.u;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name, exp_q.pop_front());
  endtask

  vec_t hv;

  initial begin
    clear = 0; load = 0; start = 0; stop = 0;
    LoadMin = 0; LoadDez = 0; LoadUni = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", 14'd0);
    @(negedge clk) rst_n = 1'b1;

    // clamp and priority
    add(0,1,0,0, 4'hC,4'h7,4'hF, 9,5,9,0,0, 1);
    add(0,0,0,0, 0,0,0,          9,5,9,0,0, 1);
    add(1,1,0,0, 1,2,3,          0,0,0,0,0, 1);
    add(0,0,1,0, 0,0,0,          0,0,0,0,0, 1);  // start at 0:00 ignored
    // basic count from 1:05
    add(0,1,0,0, 1,0,5, 1,0,5,0,0, 1);
    add(0,0,1,0, 0,0,0, 1,0,5,1,0, 1);
    add(0,0,0,0, 0,0,0, 1,0,5,1,0, 1);
    add(0,1,0,0, 3,3,3, 1,0,5,1,0, 1);           // load while running ignored
    add(0,0,0,0, 0,0,0, 1,0,5,1,0, 1);
    add(0,0,0,0, 0,0,0, 1,0,4,1,0, 4);
    add(0,0,0,0, 0,0,0, 1,0,3,1,0, 1);
    // borrow chain
    add(1,0,0,0, 0,0,0, 0,0,0,0,0, 1);
    add(0,1,0,0, 1,0,0, 1,0,0,0,0, 1);
    add(0,0,1,0, 0,0,0, 1,0,0,1,0, 1);
    add(0,0,0,0, 0,0,0, 1,0,0,1,0, 3);
    add(0,0,0,0, 0,0,0, 0,5,9,1,0, 1);
    add(0,0,0,1, 0,0,0, 0,5,9,0,0, 1);
    add(0,1,0,0, 0,1,0, 0,1,0,0,0, 1);           // load from PAUSED
    add(0,0,1,0, 0,0,0, 0,1,0,1,0, 1);
    add(0,0,0,0, 0,0,0, 0,1,0,1,0, 3);
    add(0,0,0,0, 0,0,0, 0,0,9,1,0, 1);
    // reach zero
    add(1,0,0,0, 0,0,0, 0,0,0,0,0, 1);
    add(0,1,0,0, 0,0,2, 0,0,2,0,0, 1);
    add(0,0,1,0, 0,0,0, 0,0,2,1,0, 1);
    add(0,0,0,0, 0,0,0, 0,0,2,1,0, 3);
    add(0,0,0,0, 0,0,0, 0,0,1,1,0, 4);
    add(0,0,0,0, 0,0,0, 0,0,0,0,1, 1);
    add(0,0,1,0, 0,0,0, 0,0,0,0,1, 1);
    add(0,0,0,1, 0,0,0, 0,0,0,0,1, 1);
    // pause and resume
    add(0,1,0,0, 0,0,5, 0,0,5,0,0, 1);           // load from DONE
    add(0,0,1,0, 0,0,0, 0,0,5,1,0, 1);
    add(0,0,0,0, 0,0,0, 0,0,5,1,0, 1);
    add(0,0,0,1, 0,0,0, 0,0,5,0,0, 1);           // prescaler held at 2
    add(0,0,0,0, 0,0,0, 0,0,5,0,0, 10);
    add(0,0,1,0, 0,0,0, 0,0,5,1,0, 1);
    add(0,0,0,0, 0,0,0, 0,0,5,1,0, 1);
    add(0,0,0,0, 0,0,0, 0,0,4,1,0, 1);
    // stop on the wrap cycle: decrement still applies
    add(0,0,0,0, 0,0,0, 0,0,4,1,0, 3);
    add(0,0,0,1, 0,0,0, 0,0,3,0,0, 1);
    add(0,0,1,0, 0,0,0, 0,0,3,1,0, 1);
    add(0,0,0,0, 0,0,0, 0,0,3,1,0, 3);
    add(0,0,0,0, 0,0,0, 0,0,2,1,0, 1);
    add(1,0,0,0, 0,0,0, 0,0,0,0,0, 1);
    // start together with stop: stop wins
    add(0,1,0,0, 0,0,3, 0,0,3,0,0, 1);
    add(0,0,1,1, 0,0,0, 0,0,3,0,0, 1);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a count
    hv.c = 0; hv.l = 1; hv.st = 0; hv.sp = 0; hv.m = 0; hv.d = 1; hv.u = 0;
    hv.exp = {4'd0, 4'd1, 4'd0, 1'b0, 1'b0};
    step(hv, "mid_load");
    hv.l = 0; hv.st = 1; hv.exp = {4'd0, 4'd1, 4'd0, 1'b1, 1'b0};
    step(hv, "mid_start");
    hv.st = 0;
    step(hv, "mid_run");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 14'd0);
    @(negedge clk) rst_n = 1'b1;
    hv.exp = 14'd0;
    step(hv, "after_reset_idle");
    hv.l = 1; hv.m = 0; hv.d = 0; hv.u = 2; hv.exp = {4'd0, 4'd0, 4'd2, 1'b0, 1'b0};
    step(hv, "post_load");
    hv.l = 0; hv.st = 1; hv.exp = {4'd0, 4'd0, 4'd2, 1'b1, 1'b0};
    step(hv, "post_start");
    hv.st = 0;
    for (int k = 0; k < 3; k++) step(hv, $sformatf("post_run%0d", k));
    hv.exp = {4'd0, 4'd0, 4'd1, 1'b1, 1'b0};
    step(hv, "post_tick");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
